cgpt_benchmark_engine: RTL

//  Parametrised, registered-output multi-mode engine: shift register, Fibonacci LFSR,

---
 rtl/cgpt_benchmark_engine.sv | 251 +++++++++++++++++++++++++
 1 files changed

// File: rtl/cgpt_benchmark_engine.sv
// Multi-mode benchmark core: shift register, Fibonacci LFSR, pattern detector and up/down counter,
// with a load/switch handshake choosing which unit drives data_out. Define BENCH_PARITY_EN to add a parity output.
module cgpt_benchmark_engine #(
    parameter int                 WIDTH     = 8,
    parameter logic [WIDTH-1:0]   LFSR_TAPS = 8'hB8,
    parameter logic [WIDTH-1:0]   LFSR_SEED = 8'h01,
    parameter int                 PAT_LEN   = 4,
    parameter logic [PAT_LEN-1:0] PATTERN   = 4'b1011
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       mode_sel,
    input  logic             mode_load,
    input  logic             data_in,
    input  logic             enable,
    output logic [WIDTH-1:0] data_out,
    output logic             valid,
    output logic             match_pulse
`ifdef BENCH_PARITY_EN
    ,
    output logic             parity
`endif
);

    localparam int                FILL_W    = $clog2(PAT_LEN + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_LEN);
    localparam logic [FILL_W-1:0] FILL_ONE  = FILL_W'(1);
    localparam logic [WIDTH-1:0]  ONE       = WIDTH'(1);
    localparam logic [WIDTH-1:0]  CNT_MAX   = {WIDTH{1'b1}};

    localparam logic [1:0] MODE_SHIFT  = 2'd0;
    localparam logic [1:0] MODE_LFSR   = 2'd1;
    localparam logic [1:0] MODE_DETECT = 2'd2;
    localparam logic [1:0] MODE_UPDOWN = 2'd3;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_SWITCH = 1'b1
    } ctrl_e;

`ifdef BENCH_PARITY_EN
    function automatic logic calc_parity(input logic [WIDTH-1:0] v);
        return ^v;
    endfunction
`endif

    ctrl_e              ctrl_q;
    ctrl_e              ctrl_d;
    logic [1:0]         mode_q;
    logic [1:0]         mode_d;

    logic               clr_shift_s;
    logic               clr_lfsr_s;
    logic               clr_detect_s;
    logic               clr_updown_s;

    logic [WIDTH-1:0]   sr_q;
    logic [WIDTH-1:0]   lfsr_q;
    logic [PAT_LEN-1:0] hist_q;
    logic [FILL_W-1:0]  fill_q;
    logic [WIDTH-1:0]   match_cnt_q;
    logic [WIDTH-1:0]   cnt_q;

    logic [WIDTH-1:0]   lfsr_step_s;
    logic [PAT_LEN-1:0] hist_step_s;
    logic [FILL_W-1:0]  fill_step_s;
    logic [WIDTH-1:0]   cnt_step_s;
    logic               hit_s;

    logic [WIDTH-1:0]   data_out_d;
    logic [WIDTH-1:0]   data_out_q;
    logic               valid_d;
    logic               valid_q;
    logic               match_pulse_d;
    logic               match_pulse_q;

    // Candidate next values of each unit; clear/hold is resolved in the unit registers.
    assign lfsr_step_s = (lfsr_q == {WIDTH{1'b0}}) ? LFSR_SEED
                                                   : {lfsr_q[WIDTH-2:0], ^(lfsr_q & LFSR_TAPS)};
    assign hist_step_s = {hist_q[PAT_LEN-2:0], data_in};
    assign fill_step_s = (fill_q == FILL_FULL) ? fill_q : (fill_q + FILL_ONE);
    assign cnt_step_s  = data_in ? (cnt_q - ONE) : (cnt_q + ONE);
    // A hit needs a full window, so the first PAT_LEN-1 bits after a clear can never match.
    assign hit_s       = enable & (hist_step_s == PATTERN) & (fill_step_s == FILL_FULL);

    // Control state and active mode register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl_q <= ST_RUN;
            mode_q <= MODE_SHIFT;
        end else begin
            ctrl_q <= ctrl_d;
            mode_q <= mode_d;
        end
    end

    // Next control state: a load of a different mode enters SWITCH for exactly one cycle.
    always_comb begin
        ctrl_d = ctrl_q;
        mode_d = mode_q;
        case (ctrl_q)
            ST_RUN: begin
                if (mode_load && (mode_sel != mode_q)) begin
                    ctrl_d = ST_SWITCH;
                    mode_d = mode_sel;
                end else begin
                    ctrl_d = ST_RUN;
                end
            end
            ST_SWITCH: begin
                ctrl_d = ST_RUN;
            end
            default: begin
                ctrl_d = ST_RUN;
            end
        endcase
    end

    // Control outputs: unit clears during SWITCH, output selection during RUN.
    always_comb begin
        clr_shift_s   = 1'b0;
        clr_lfsr_s    = 1'b0;
        clr_detect_s  = 1'b0;
        clr_updown_s  = 1'b0;
        data_out_d    = {WIDTH{1'b0}};
        valid_d       = 1'b0;
        match_pulse_d = 1'b0;
        case (ctrl_q)
            ST_SWITCH: begin
                case (mode_q)
                    MODE_SHIFT:  clr_shift_s  = 1'b1;
                    MODE_LFSR:   clr_lfsr_s   = 1'b1;
                    MODE_DETECT: clr_detect_s = 1'b1;
                    MODE_UPDOWN: clr_updown_s = 1'b1;
                    default:     clr_shift_s  = 1'b0;
                endcase
            end
            ST_RUN: begin
                valid_d       = 1'b1;
                match_pulse_d = hit_s & (mode_q == MODE_DETECT);
                case (mode_q)
                    MODE_SHIFT:  data_out_d = sr_q;
                    MODE_LFSR:   data_out_d = lfsr_q;
                    MODE_DETECT: data_out_d = match_cnt_q;
                    MODE_UPDOWN: data_out_d = cnt_q;
                    default:     data_out_d = sr_q;
                endcase
            end
            default: begin
                valid_d = 1'b0;
            end
        endcase
    end

    // Shift register unit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sr_q <= {WIDTH{1'b0}};
        end else if (clr_shift_s) begin
            sr_q <= {WIDTH{1'b0}};
        end else if (enable) begin
            sr_q <= {sr_q[WIDTH-2:0], data_in};
        end else begin
            sr_q <= sr_q;
        end
    end

    // LFSR unit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr_q <= LFSR_SEED;
        end else if (clr_lfsr_s) begin
            lfsr_q <= LFSR_SEED;
        end else if (enable) begin
            lfsr_q <= lfsr_step_s;
        end else begin
            lfsr_q <= lfsr_q;
        end
    end

    // Pattern detector unit: history window, fill level and saturating hit counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hist_q      <= {PAT_LEN{1'b0}};
            fill_q      <= {FILL_W{1'b0}};
            match_cnt_q <= {WIDTH{1'b0}};
        end else if (clr_detect_s) begin
            hist_q      <= {PAT_LEN{1'b0}};
            fill_q      <= {FILL_W{1'b0}};
            match_cnt_q <= {WIDTH{1'b0}};
        end else if (enable) begin
            hist_q <= hist_step_s;
            fill_q <= fill_step_s;
            if (hit_s && (match_cnt_q != CNT_MAX)) begin
                match_cnt_q <= match_cnt_q + ONE;
            end else begin
                match_cnt_q <= match_cnt_q;
            end
        end else begin
            hist_q      <= hist_q;
            fill_q      <= fill_q;
            match_cnt_q <= match_cnt_q;
        end
    end

    // Up/down counter unit, wrapping in both directions.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= {WIDTH{1'b0}};
        end else if (clr_updown_s) begin
            cnt_q <= {WIDTH{1'b0}};
        end else if (enable) begin
            cnt_q <= cnt_step_s;
        end else begin
            cnt_q <= cnt_q;
        end
    end

    // Registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_out_q    <= {WIDTH{1'b0}};
            valid_q       <= 1'b0;
            match_pulse_q <= 1'b0;
        end else begin
            data_out_q    <= data_out_d;
            valid_q       <= valid_d;
            match_pulse_q <= match_pulse_d;
        end
    end

    assign data_out    = data_out_q;
    assign valid       = valid_q;
    assign match_pulse = match_pulse_q;

`ifdef BENCH_PARITY_EN
    logic parity_q;

    // Parity of the value being registered; data_out_d is already zero during SWITCH.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= calc_parity(data_out_d);
        end
    end

    assign parity = parity_q;
`endif

endmodule
